// File: rtl/matmul_apb_master.sv
// matmul_apb_master: turns a valid/ready command stream into single APB
// SETUP/ACCESS transfers toward the matmul accelerator's register port and
// returns one response per command. Only one transfer is in flight.
// Optional feature macro: APB_TIMEOUT_EN bounds the ACCESS-phase wait to
// TIMEOUT_CYC cycles and reports a timeout as an error response.
module matmul_apb_master #(
  parameter int DW          = 8,
  parameter int BW          = 32,
  parameter int ADDR_W      = 16,
  parameter int MAX_DIM     = BW / DW,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_write_i,
  input  logic [ADDR_W-1:0]  cmd_addr_i,
  input  logic [BW-1:0]      cmd_wdata_i,
  input  logic [MAX_DIM-1:0] cmd_strb_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [BW-1:0]      rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               psel_o,
  output logic               penable_o,
  output logic               pwrite_o,
  output logic [MAX_DIM-1:0] pstrb_o,
  output logic [BW-1:0]      pwdata_o,
  output logic [ADDR_W-1:0]  paddr_o,
  input  logic               pready_i,
  input  logic               pslverr_i,
  input  logic [BW-1:0]      prdata_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic               accept;
  logic               misaligned;
  logic               pwrite_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [BW-1:0]      pwdata_q;
  logic [MAX_DIM-1:0] pstrb_q;
  logic [BW-1:0]      rdata_q;
  logic               err_q;

  assign accept     = (state_q == IDLE) && cmd_valid_i;
  assign misaligned = (cmd_addr_i[1:0] != 2'b00);

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 255) ? 16 : 8;
  logic [TO_W-1:0] to_cnt_q;
  logic            to_hit;

  // The TIMEOUT_CYC-th ACCESS cycle without pready ends the transfer;
  // pready in that same cycle takes priority because it is tested first.
  assign to_hit = !pready_i && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Wait counter: cleared while entering ACCESS, counts stalled ACCESS cycles.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      to_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      to_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !pready_i) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`endif

  // State register; async reset drops psel/penable immediately.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic for the single-outstanding APB transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (cmd_valid_i) state_d = misaligned ? RESP : SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready_i) state_d = RESP;
`ifdef APB_TIMEOUT_EN
        else if (to_hit) state_d = RESP;
`endif
      end
      RESP:   if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch: bus fields hold from SETUP until the next accept.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (accept) begin
      pwrite_q <= cmd_write_i;
      paddr_q  <= cmd_addr_i;
      pwdata_q <= cmd_wdata_i;
      pstrb_q  <= cmd_write_i ? cmd_strb_i : '0;
    end
  end

  // Response capture: misalignment, completed transfer, or timeout.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept && misaligned) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end else if ((state_q == ACCESS) && pready_i) begin
      rdata_q <= (pwrite_q || pslverr_i) ? '0 : prdata_i;
      err_q   <= pslverr_i;
`ifdef APB_TIMEOUT_EN
    end else if ((state_q == ACCESS) && to_hit) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
`endif
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
